// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops words from a FIFO read port and sends each one as a UART
// frame on a single line (start bit, WIDTH data bits LSB first, optional
// parity bit, one stop bit).
//
// Ports:
//   i_clk    system clock, rising edge
//   i_rest   asynchronous reset, active-low
//   i_en     transmit enable, sampled only while idle
//   i_empty  FIFO empty flag
//   i_data   FIFO read data, valid the cycle after o_ren
//   o_ren    FIFO read strobe, one cycle per popped word
//   o_tx     serial line, idles high
//   o_busy   high whenever a pop or frame is in progress
//   o_done   one-cycle pulse in the first idle cycle after a stop bit
module fifo_uart_tx #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY       = 0
) (
  input  logic             i_clk,
  input  logic             i_rest,
  input  logic             i_en,
  input  logic             i_empty,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_ren,
  output logic             o_tx,
  output logic             o_busy,
  output logic             o_done
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_POP   = 3'd1,
    S_WAIT  = 3'd2,
    S_START = 3'd3,
    S_DATA  = 3'd4,
    S_PAR   = 3'd5,
    S_STOP  = 3'd6
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic               par_q, par_d;
  logic               done_q, done_d;
  logic               bit_end;

  // State and datapath registers
  always_ff @(posedge i_clk or negedge i_rest) begin
    if (!i_rest) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      done_q  <= done_d;
    end
  end

  assign bit_end = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

  // Next-state, bit timer, bit index and shift/parity load
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_en && !i_empty) state_d = S_POP;
      end
      S_POP: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Only place the word and its parity are captured.
        shift_d = i_data;
        par_d   = (^i_data) ^ (PARITY == 2);
        cnt_d   = '0;
        idx_d   = '0;
        state_d = S_START;
      end
      S_START: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          idx_d   = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(WIDTH - 1)) begin
            state_d = (PARITY != 0) ? S_PAR : S_STOP;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_PAR: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (bit_end) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decoded from registers only
  always_comb begin
    o_tx = 1'b1;
    case (state_q)
      S_START: o_tx = 1'b0;
      S_DATA:  o_tx = shift_q[0];
      S_PAR:   o_tx = par_q;
      default: o_tx = 1'b1;
    endcase
  end

  assign o_ren  = (state_q == S_POP);
  assign o_busy = (state_q != S_IDLE);
  assign o_done = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx at CLKS_PER_BIT=4, WIDTH=8.
// Each cycle compares {o_ren, o_tx, o_busy, o_done} on the falling edge
// against an expected frame waveform computed from the frame format.
module tb_fifo_uart_tx;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Main DUT, no parity, fed by a small bench FIFO
  logic       en, empty, ren, tx, busy, done;
  logic [7:0] rdata = 8'h00;
  logic [7:0] mem [0:15];
  logic [3:0] wr_ptr = 4'd0;
  logic [3:0] rd_ptr = 4'd0;

  assign empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (ren) begin
      rdata  <= mem[rd_ptr];
      rd_ptr <= rd_ptr + 4'd1;
    end
  end

  fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY(0)) dut (
    .i_clk(clk), .i_rest(rst_n), .i_en(en), .i_empty(empty), .i_data(rdata),
    .o_ren(ren), .o_tx(tx), .o_busy(busy), .o_done(done)
  );

  // Parity instances, fixed word 0x07
  logic       en_p, empty_p;
  logic [7:0] data_p = 8'h07;
  logic       ren_e, tx_e, busy_e, done_e;
  logic       ren_o, tx_o, busy_o, done_o;

  fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY(1)) dut_even (
    .i_clk(clk), .i_rest(rst_n), .i_en(en_p), .i_empty(empty_p), .i_data(data_p),
    .o_ren(ren_e), .o_tx(tx_e), .o_busy(busy_e), .o_done(done_e)
  );

  fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY(2)) dut_odd (
    .i_clk(clk), .i_rest(rst_n), .i_en(en_p), .i_empty(empty_p), .i_data(data_p),
    .o_ren(ren_o), .o_tx(tx_o), .o_busy(busy_o), .o_done(done_o)
  );

  int errors = 0;
  int checks = 0;

  // Expected {ren, tx, busy, done} at cycle m after IDLE saw a non-empty FIFO.
  // m=1 POP, m=2 WAIT, m=3.. start bit, 4 cycles per bit.
  function automatic logic [3:0] exp_frame(input logic [7:0] w, input int par_mode, input int m);
    int  nbits;
    int  stop_end;
    logic t;
    nbits    = (par_mode != 0) ? 11 : 10;
    stop_end = 2 + nbits * 4;
    t = 1'b1;
    if (m >= 3 && m <= 6) t = 1'b0;
    else if (m >= 7 && m <= 38) t = w[(m - 7) / 4];
    else if (par_mode != 0 && m >= 39 && m <= 42) t = (par_mode == 1) ? (^w) : ~(^w);
    return {(m == 1), t, (m >= 1 && m <= stop_end), (m == stop_end + 1)};
  endfunction

  task automatic push(input logic [7:0] w);
    mem[wr_ptr] = w;
    wr_ptr = wr_ptr + 4'd1;
  endtask

  task automatic test_reset();
    logic [3:0] got;
    rst_n = 1'b0; en = 1'b0; en_p = 1'b0; empty_p = 1'b1;
    #1;
    got = {ren, tx, busy, done};
    checks++;
    if (got !== 4'b0100) begin
      errors++;
      $display("FAIL reset_assert got=%b exp=0100", got);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;
    for (int n = 1; n <= 50; n++) begin
      @(negedge clk);
      got = {ren, tx, busy, done};
      checks++;
      if (got !== 4'b0100) begin
        errors++;
        $display("FAIL idle_empty n=%0d got=%b exp=0100", n, got);
      end
    end
  endtask

  task automatic test_single_frame();
    logic [3:0] got, exp;
    int ren_cnt = 0, done_cnt = 0;
    @(negedge clk);
    push(8'hA5);
    for (int n = 1; n <= 50; n++) begin
      @(negedge clk);
      got = {ren, tx, busy, done};
      exp = exp_frame(8'hA5, 0, n);
      ren_cnt  += int'(ren);
      done_cnt += int'(done);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL single_a5 n=%0d got=%b exp=%b", n, got, exp);
      end
    end
    checks++;
    if (ren_cnt != 1 || done_cnt != 1) begin
      errors++;
      $display("FAIL single_counts ren=%0d done=%0d exp=1/1", ren_cnt, done_cnt);
    end
  endtask

  task automatic test_parity();
    logic [3:0] got_e, got_o, exp_e, exp_o;
    @(negedge clk);
    en_p    = 1'b1;
    empty_p = 1'b0;
    for (int n = 1; n <= 55; n++) begin
      @(negedge clk);
      empty_p = 1'b1;
      got_e = {ren_e, tx_e, busy_e, done_e};
      got_o = {ren_o, tx_o, busy_o, done_o};
      exp_e = exp_frame(8'h07, 1, n);
      exp_o = exp_frame(8'h07, 2, n);
      checks++;
      if (got_e !== exp_e) begin
        errors++;
        $display("FAIL parity_even n=%0d got=%b exp=%b", n, got_e, exp_e);
      end
      checks++;
      if (got_o !== exp_o) begin
        errors++;
        $display("FAIL parity_odd n=%0d got=%b exp=%b", n, got_o, exp_o);
      end
    end
    en_p = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [0:2];
    logic [3:0] got, exp;
    int k, m, ren_cnt;
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
    ren_cnt = 0;
    @(negedge clk);
    push(8'h11); push(8'h22); push(8'h33);
    for (int n = 1; n <= 150; n++) begin
      @(negedge clk);
      k = (n - 1) / 43;
      m = ((n - 1) % 43) + 1;
      exp = (k <= 2) ? exp_frame(words[k], 0, m) : 4'b0100;
      got = {ren, tx, busy, done};
      ren_cnt += int'(ren);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL b2b n=%0d got=%b exp=%b", n, got, exp);
      end
    end
    checks++;
    if (ren_cnt != 3) begin
      errors++;
      $display("FAIL b2b_ren_count got=%0d exp=3", ren_cnt);
    end
  endtask

  task automatic test_enable_drop();
    logic [3:0] got, exp;
    @(negedge clk);
    push(8'h3C); push(8'h55); push(8'h77);
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      got = {ren, tx, busy, done};
      exp = exp_frame(8'h3C, 0, n);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL en_drop n=%0d got=%b exp=%b", n, got, exp);
      end
      if (n == 20) en = 1'b0;  // inside data bit 3
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [3:0] got, exp;
    @(negedge clk);
    en = 1'b1;
    for (int n = 1; n <= 15; n++) begin
      @(negedge clk);
      got = {ren, tx, busy, done};
      exp = exp_frame(8'h55, 0, n);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL pre_rst n=%0d got=%b exp=%b", n, got, exp);
      end
    end
    #1 rst_n = 1'b0;
    #1;
    got = {ren, tx, busy, done};
    checks++;
    if (got !== 4'b0100) begin
      errors++;
      $display("FAIL async_rst got=%b exp=0100", got);
    end
    #1 rst_n = 1'b1;
    for (int n = 1; n <= 50; n++) begin
      @(negedge clk);
      got = {ren, tx, busy, done};
      exp = exp_frame(8'h77, 0, n);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL post_rst n=%0d got=%b exp=%b", n, got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_parity();
    test_back_to_back();
    test_enable_drop();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Read-side consumer for the FIFO block. It pops words through the FIFO's read-enable/empty interface and serialises each word as an asynchronous UART frame on a single line.
- Frame format: start bit, WIDTH data bits LSB first, optional parity bit, one stop bit.
- Sits between the FIFO read port and the board TX pin; the FIFO write side is fed by the rest of the design.

Parameters:
- WIDTH, 8, data word width; must match the FIFO WIDTH.
- CLKS_PER_BIT, 16, i_clk cycles per serial bit; legal range >= 2.
- PARITY, 0, parity mode: 0 = none, 1 = even, 2 = odd.

Ports:
- i_clk  input  1  system clock, rising edge.
- i_rest  input  1  asynchronous reset, active-low.
- i_en  input  1  transmit enable; checked only in IDLE.
- i_empty  input  1  FIFO empty flag.
- i_data  input  WIDTH  FIFO read data; valid the cycle after o_ren is high.
- o_ren  output  1  FIFO read strobe, one cycle per popped word.
- o_tx  output  1  serial line; idle level is high.
- o_busy  output  1  high in every state except IDLE.
- o_done  output  1  one-cycle pulse after each frame's stop bit.

Behaviour:
- Reset (i_rest=0, asynchronous, takes effect immediately):
  - state = IDLE; o_tx = 1; o_ren = 0; o_busy = 0; o_done = 0.
  - Bit timer, bit index and shift register cleared.
- All outputs are registered or decoded directly from the state register; no combinational path from inputs to outputs.
- States: IDLE, POP, WAIT, START, DATA, PAR, STOP.
- IDLE:
  - o_tx = 1.
  - If i_en=1 and i_empty=0 at the clock edge, go to POP. Otherwise stay.
- POP (exactly 1 cycle): o_ren = 1, then go to WAIT.
- WAIT (exactly 1 cycle):
  - i_data is valid.
  - At the end of the cycle: shift register <= i_data; parity bit = XOR of i_data (inverted when PARITY=2); go to START.
- START:
  - o_tx = 0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - o_tx = shift register bit 0 for CLKS_PER_BIT cycles.
  - Then shift right and increment the bit index.
  - After WIDTH bits: go to PAR if PARITY != 0, else STOP.
- PAR: o_tx = parity bit for CLKS_PER_BIT cycles, then go to STOP.
- STOP:
  - o_tx = 1 for CLKS_PER_BIT cycles, then go to IDLE.
  - o_done = 1 for the first IDLE cycle only.
- Bit timer:
  - Counts 0 .. CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT).
  - Reloads to 0 on every bit boundary.
- Bit index width: $clog2(WIDTH+1).
- Latency: IDLE edge sampling i_en & !i_empty at cycle t -> o_ren high at t+1 -> start bit begins at t+3.
- Frame length: (2 + WIDTH + (PARITY!=0)) * CLKS_PER_BIT cycles, counted from the start of START to the end of STOP.
- Back-to-back frames: at least 3 high cycles between the end of a stop bit and the next start bit (IDLE, POP, WAIT). No other gap is inserted.
- Underflow protection: o_ren is never asserted while i_empty=1 was sampled in IDLE. No pop is issued outside POP.
- i_en deasserted mid-frame: the current frame completes normally. No new pop follows.
- i_empty changing mid-frame: ignored until IDLE.
- Reset mid-frame:
  - o_tx returns high immediately; the partially sent word is lost.
  - The FIFO pointer has already advanced, so the word is not re-read.
- Parity and shift-register state are only ever loaded in WAIT. Garbage on i_data in other cycles has no effect.

Test Plan:
1. Reset and idle
   - Stimulus: i_rest=0, then 1; i_en=1; i_empty=1 for 50 cycles.
   - Required: o_tx=1, o_ren=0, o_busy=0, o_done=0 throughout.
2. Single frame, 8N1
   - Setup: WIDTH=8, CLKS_PER_BIT=4, PARITY=0; i_en=1; i_empty falls at cycle t; FIFO returns 0xA5.
   - Required: o_ren high only at t+1; o_tx=0 over cycles t+3..t+6.
   - Data bits 1,0,1,0,0,1,0,1, 4 cycles each.
   - Stop bit high for 4 cycles; o_done pulses exactly once, 40 cycles after start-bit begin; one o_ren total.
3. Parity
   - Setup: PARITY=1 with word 0x07 -> parity bit 1; PARITY=2 with word 0x07 -> parity bit 0.
   - Required: frame length 44 cycles at CLKS_PER_BIT=4.
4. Back-to-back drain
   - Stimulus: FIFO preloaded with 0x11, 0x22, 0x33; i_en held high.
   - Required: three frames in order, exactly 3 o_ren pulses, 3 high cycles between frames.
   - No o_ren after i_empty rises.
5. Enable drop mid-frame
   - Stimulus: i_en=0 during DATA bit 3 of 0x3C.
   - Required: the frame completes intact and o_done pulses; then o_busy=0 and no further o_ren while the FIFO is non-empty.
6. Asynchronous reset mid-frame
   - Stimulus: i_rest=0 for 2 ns between clock edges during DATA.
   - Required: o_tx=1 and o_busy=0 before the next clock edge.
   - After release, the next frame carries the following FIFO word.
